hsk_io_port: RTL and testbench
==============================

# hsk_io_port

Byte-wide external I/O port that runs the four-phase `hsk_in`/`hsk_out` handshake on `bus_in`/`bus_out` for the processor. On the input side it buffers received bytes in a small FIFO that the controller drains into `Rin`. On the output side it holds one byte from `R_OUT` until the external device acknowledges it. The port sits directly between the processor pins and the stage-two/stage-three I/O registers. The controller sees only simple valid/busy flags, never the raw handshake.

## Interface
Parameters:
- `WIDTH`, 8: data width of the bus and the FIFO.
- `DEPTH`, 4: input FIFO depth. Must be a power of 2 and ≥2.

Ports:
- `g_clk`  in  1: system clock. All state updates on the rising edge.
- `g_clr`  in  1: asynchronous, active-high reset.
- `bus_in`  in  WIDTH: external input data. Must be stable while `hsk_in` is high during an input transfer.
- `hsk_in`  in  1: external request (input transfer) or acknowledge (output transfer). Asynchronous to `g_clk`.
- `bus_out`  out  WIDTH: external output data. Registered.
- `hsk_out`  out  1: block acknowledge (input transfer) or request (output transfer). Registered.
- `rd_req`  in  1: controller pops the FIFO head.
- `rd_data`  out  WIDTH: FIFO head (show-ahead). 0 when empty.
- `rd_valid`  out  1: FIFO non-empty.
- `in_full`  out  1: FIFO holds DEPTH entries.
- `wr_req`  in  1: controller offers `wr_data` for output.
- `wr_data`  in  WIDTH: output byte, normally `R_OUT`.
- `wr_busy`  out  1: output holding register occupied. A `wr_req` is ignored while high.

## Operation
- `hsk_in` passes through a 2-flop synchronizer. The result `hs` is used everywhere below.
- The handshake FSM has 4 states:
  - IDLE: `hsk_out`=0.
    - If `hs`=1 and not `in_full`: push `bus_in` into the FIFO and go to IN_ACK. Input has priority.
    - Else if `hs`=0 and `wr_busy`: load `bus_out` from the holding register and go to OUT_REQ.
    - If `hs`=1 and `in_full`: stay in IDLE with `hsk_out` low (backpressure).
  - IN_ACK: `hsk_out`=1. Wait for `hs`=0, then go to IDLE.
  - OUT_REQ: `hsk_out`=1. Wait for `hs`=1, then clear `wr_busy` and go to OUT_REL.
  - OUT_REL: `hsk_out`=0. Wait for `hs`=0, then go to IDLE.
- External-side contract: the device raises `hsk_in` only while `hsk_out` is low and the port is in IDLE. If `hsk_out` rises without a request from the device, the transfer is an output transfer.
- Output holding register: `wr_req` while `wr_busy`=0 captures `wr_data` and sets `wr_busy`. A `wr_req` while busy is dropped with no effect.
- `bus_out` keeps its last driven value after a transfer completes.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH, plus a count 0..DEPTH.
  - `rd_req` with `rd_valid`=0 is ignored.
  - Push and pop in the same cycle (non-empty): both occur and the count is unchanged.
  - Push is decided on `in_full` at the start of the cycle. A same-cycle pop does not admit a push when full.
- Reset, asynchronous: state IDLE, both synchronizer flops 0, `hsk_out` 0, `bus_out` 0, `wr_busy` 0, FIFO empty (`rd_valid` 0, `in_full` 0, `rd_data` 0). A transfer interrupted by reset is abandoned. The external device sees `hsk_out` drop immediately.

## Timing
- `hsk_in` rise to `hs` high: 2 clocks. Capture happens on the edge `hs` is seen in IDLE. `hsk_out` rises on that edge (3 edges after `hsk_in`).
- `rd_valid` goes high on the same edge as the push.
- `rd_data` follows the head combinationally from the pointer and storage registers.
- `wr_req` to `wr_busy` high: 1 edge. The FSM may enter OUT_REQ on the next edge if IDLE and `hs`=0.
- `wr_busy` clears on the edge the ack is seen. A new `wr_req` is accepted the following cycle, but the port does not start a new transfer until it returns to IDLE.
- Minimum full cycle per transfer is about 6 clocks: 2 synchronizer edges per `hsk_in` transition plus the FSM edges.

## Test plan
- Reset mid-transfer: assert `g_clr` while in OUT_REQ -> `hsk_out`=0, `bus_out`=0x00, `wr_busy`=0 immediately. After release, the FSM is in IDLE.
- Single input: `bus_in`=0xA5, raise `hsk_in` -> `hsk_out` high at the 3rd edge and `rd_valid`=1 with `rd_data`=0xA5. Drop `hsk_in` -> `hsk_out` low 3 edges later. `rd_req` -> `rd_valid`=0.
- Backpressure and wrap (DEPTH=4): push 0x01..0x04 -> `in_full`=1. A 5th request (0x05) holds `hsk_out` low. One `rd_req` pops 0x01, then 0x05 is accepted. Pop order: 0x02, 0x03, 0x04, 0x05.
- Output: `wr_req` with 0x3C -> `wr_busy`=1, then `bus_out`=0x3C and `hsk_out`=1. Ack via `hsk_in` -> `wr_busy`=0 and `hsk_out`=0. A second `wr_req` during busy (0x77) is dropped.
- Priority: `hs`=1 and `wr_busy`=1 in IDLE -> input transfer completes first, then the output transfer.
- Simultaneous push and pop with count=2 -> count stays 2 and the head advances.

Source files
------------

// File: rtl/hsk_io_port_if.sv
// Signal bundle for hsk_io_port: the external four-phase handshake pins plus
// the controller-side FIFO read and output-write channels.
interface hsk_io_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] bus_in;
  logic             hsk_in;
  logic [WIDTH-1:0] bus_out;
  logic             hsk_out;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             in_full;
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             wr_busy;

  modport slave (
    input  bus_in, hsk_in, rd_req, wr_req, wr_data,
    output bus_out, hsk_out, rd_data, rd_valid, in_full, wr_busy
  );

  modport master (
    output bus_in, hsk_in, rd_req, wr_req, wr_data,
    input  bus_out, hsk_out, rd_data, rd_valid, in_full, wr_busy
  );
endinterface

// File: rtl/hsk_io_port.sv
// Byte-wide I/O port: four-phase handshake FSM, show-ahead input FIFO and a
// single-entry output holding register behind simple valid/busy flags.
module hsk_io_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic          g_clk,
  input logic          g_clr,
  hsk_io_port_if.slave io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IN_ACK  = 2'd1;
  localparam logic [1:0] OUT_REQ = 2'd2;
  localparam logic [1:0] OUT_REL = 2'd3;

  logic             sync1;
  logic             hs;
  logic [1:0]       state;
  logic             hsk_q;
  logic [WIDTH-1:0] bus_q;
  logic             busy;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             valid;
  logic             push;
  logic             pop;
  logic             out_start;
  logic             ack_seen;

  // hsk_in is asynchronous to g_clk; only the second flop is ever used.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      sync1 <= 1'b0;
      hs    <= 1'b0;
    end else begin
      sync1 <= io.hsk_in;
      hs    <= sync1;
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign valid     = (count != '0);
  assign push      = (state == IDLE) && hs && !full;
  assign pop       = io.rd_req && valid;
  assign out_start = (state == IDLE) && !hs && busy;
  assign ack_seen  = (state == OUT_REQ) && hs;

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state <= IDLE;
      hsk_q <= 1'b0;
      bus_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state <= IN_ACK;
            hsk_q <= 1'b1;
          end else if (out_start) begin
            state <= OUT_REQ;
            hsk_q <= 1'b1;
            bus_q <= hold;
          end
        end
        IN_ACK: begin
          if (!hs) begin
            state <= IDLE;
            hsk_q <= 1'b0;
          end
        end
        OUT_REQ: begin
          if (hs) begin
            state <= OUT_REL;
            hsk_q <= 1'b0;
          end
        end
        default: begin
          if (!hs) state <= IDLE;
        end
      endcase
    end
  end

  // Set and clear never collide: set needs busy low, the ack needs it high.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      busy <= 1'b0;
      hold <= '0;
    end else if (ack_seen) begin
      busy <= 1'b0;
    end else if (io.wr_req && !busy) begin
      busy <= 1'b1;
      hold <= io.wr_data;
    end
  end

  always_ff @(posedge g_clk) begin
    if (push) mem[wr_ptr] <= io.bus_in;
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io.rd_data  = valid ? mem[rd_ptr] : '0;
  assign io.rd_valid = valid;
  assign io.in_full  = full;
  assign io.wr_busy  = busy;
  assign io.hsk_out  = hsk_q;
  assign io.bus_out  = bus_q;

endmodule

// File: tb/tb_hsk_io_port.sv
// Directed self-checking bench for hsk_io_port: reset, input, backpressure,
// output, priority, push/pop overlap and reset in the middle of a transfer.
module tb_hsk_io_port;

  logic g_clk = 1'b0;
  logic g_clr = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  hsk_io_port_if #(.WIDTH(8)) io ();

  hsk_io_port #(.WIDTH(8), .DEPTH(4)) dut (
    .g_clk(g_clk),
    .g_clr(g_clr),
    .io   (io)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  // Device side of an input transfer, with bounded waits on hsk_out.
  task automatic device_send(input logic [7:0] d, output bit ok);
    int k;
    ok        = 1'b1;
    io.bus_in = d;
    io.hsk_in = 1'b1;
    k = 0;
    while (io.hsk_out !== 1'b1 && k < 20) begin tick(); k++; end
    if (io.hsk_out !== 1'b1) ok = 1'b0;
    io.hsk_in = 1'b0;
    k = 0;
    while (io.hsk_out !== 1'b0 && k < 20) begin tick(); k++; end
    if (io.hsk_out !== 1'b0) ok = 1'b0;
  endtask

  task automatic pop_once();
    io.rd_req = 1'b1;
    tick();
    io.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    io.bus_in = 8'h00; io.hsk_in = 1'b0; io.rd_req = 1'b0;
    io.wr_req = 1'b0;  io.wr_data = 8'h00;
    g_clr = 1'b1;
    tick(2);
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL rst_hsk_out: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    if (io.bus_out !== 8'h00) begin $display("[TB] FAIL rst_bus_out: got %h want 00", io.bus_out); n_bad++; end n_cmp++;
    if (io.wr_busy !== 1'b0) begin $display("[TB] FAIL rst_wr_busy: got %b want 0", io.wr_busy); n_bad++; end n_cmp++;
    if (io.rd_valid !== 1'b0) begin $display("[TB] FAIL rst_rd_valid: got %b want 0", io.rd_valid); n_bad++; end n_cmp++;
    if (io.in_full !== 1'b0) begin $display("[TB] FAIL rst_in_full: got %b want 0", io.in_full); n_bad++; end n_cmp++;
    if (io.rd_data !== 8'h00) begin $display("[TB] FAIL rst_rd_data: got %h want 00", io.rd_data); n_bad++; end n_cmp++;
    g_clr = 1'b0;
    tick();
  endtask

  task automatic test_single_input();
    io.bus_in = 8'hA5;
    io.hsk_in = 1'b1;
    tick(2);
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL in_ack_early: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    tick();
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL in_ack_edge3: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    if (io.rd_valid !== 1'b1) begin $display("[TB] FAIL in_rd_valid: got %b want 1", io.rd_valid); n_bad++; end n_cmp++;
    if (io.rd_data !== 8'hA5) begin $display("[TB] FAIL in_rd_data: got %h want a5", io.rd_data); n_bad++; end n_cmp++;
    io.hsk_in = 1'b0;
    tick(2);
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL in_rel_early: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    tick();
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL in_rel_edge3: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    pop_once();
    if (io.rd_valid !== 1'b0) begin $display("[TB] FAIL in_pop_empty: got %b want 0", io.rd_valid); n_bad++; end n_cmp++;
    pop_once();
    if (io.rd_valid !== 1'b0) begin $display("[TB] FAIL in_pop_underflow: got %b want 0", io.rd_valid); n_bad++; end n_cmp++;
    if (io.rd_data !== 8'h00) begin $display("[TB] FAIL in_empty_data: got %h want 00", io.rd_data); n_bad++; end n_cmp++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] exp_pop [4];
    exp_pop[0] = 8'h02; exp_pop[1] = 8'h03; exp_pop[2] = 8'h04; exp_pop[3] = 8'h05;
    for (int i = 1; i <= 4; i++) begin
      device_send(8'(i), ok);
      if (!ok) begin $display("[TB] FAIL bp_send%0d: got timeout want handshake", i); n_bad++; end n_cmp++;
    end
    if (io.in_full !== 1'b1) begin $display("[TB] FAIL bp_full: got %b want 1", io.in_full); n_bad++; end n_cmp++;
    io.bus_in = 8'h05;
    io.hsk_in = 1'b1;
    tick(6);
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL bp_hold_low: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    if (io.rd_data !== 8'h01) begin $display("[TB] FAIL bp_head: got %h want 01", io.rd_data); n_bad++; end n_cmp++;
    pop_once();
    if (io.rd_data !== 8'h02) begin $display("[TB] FAIL bp_head_after_pop: got %h want 02", io.rd_data); n_bad++; end n_cmp++;
    if (io.in_full !== 1'b0) begin $display("[TB] FAIL bp_not_full: got %b want 0", io.in_full); n_bad++; end n_cmp++;
    tick();
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL bp_accept: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    if (io.in_full !== 1'b1) begin $display("[TB] FAIL bp_refull: got %b want 1", io.in_full); n_bad++; end n_cmp++;
    io.hsk_in = 1'b0;
    tick(3);
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL bp_release: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    for (int i = 0; i < 4; i++) begin
      if (io.rd_data !== exp_pop[i]) begin $display("[TB] FAIL bp_pop%0d: got %h want %h", i, io.rd_data, exp_pop[i]); n_bad++; end n_cmp++;
      pop_once();
    end
    if (io.rd_valid !== 1'b0) begin $display("[TB] FAIL bp_drained: got %b want 0", io.rd_valid); n_bad++; end n_cmp++;
  endtask

  task automatic test_output();
    io.wr_data = 8'h3C;
    io.wr_req  = 1'b1;
    tick();
    io.wr_req = 1'b0;
    if (io.wr_busy !== 1'b1) begin $display("[TB] FAIL out_busy: got %b want 1", io.wr_busy); n_bad++; end n_cmp++;
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL out_req_early: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    tick();
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL out_req: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    if (io.bus_out !== 8'h3C) begin $display("[TB] FAIL out_bus: got %h want 3c", io.bus_out); n_bad++; end n_cmp++;
    io.wr_data = 8'h77;
    io.wr_req  = 1'b1;
    tick();
    io.wr_req = 1'b0;
    if (io.bus_out !== 8'h3C) begin $display("[TB] FAIL out_drop_bus: got %h want 3c", io.bus_out); n_bad++; end n_cmp++;
    io.hsk_in = 1'b1;
    tick(2);
    if (io.wr_busy !== 1'b1) begin $display("[TB] FAIL out_ack_early: got %b want 1", io.wr_busy); n_bad++; end n_cmp++;
    tick();
    if (io.wr_busy !== 1'b0) begin $display("[TB] FAIL out_ack_busy: got %b want 0", io.wr_busy); n_bad++; end n_cmp++;
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL out_ack_hsk: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    io.hsk_in = 1'b0;
    tick(8);
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL out_no_resend: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    if (io.wr_busy !== 1'b0) begin $display("[TB] FAIL out_dropped_req: got %b want 0", io.wr_busy); n_bad++; end n_cmp++;
    if (io.bus_out !== 8'h3C) begin $display("[TB] FAIL out_bus_hold: got %h want 3c", io.bus_out); n_bad++; end n_cmp++;
  endtask

  task automatic test_priority();
    io.bus_in = 8'hC3;
    io.hsk_in = 1'b1;
    tick();
    io.wr_data = 8'h5A;
    io.wr_req  = 1'b1;
    tick();
    io.wr_req = 1'b0;
    tick();
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL pri_in_ack: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    if (io.rd_data !== 8'hC3) begin $display("[TB] FAIL pri_in_data: got %h want c3", io.rd_data); n_bad++; end n_cmp++;
    if (io.wr_busy !== 1'b1) begin $display("[TB] FAIL pri_busy: got %b want 1", io.wr_busy); n_bad++; end n_cmp++;
    if (io.bus_out !== 8'h3C) begin $display("[TB] FAIL pri_bus_old: got %h want 3c", io.bus_out); n_bad++; end n_cmp++;
    io.hsk_in = 1'b0;
    tick(3);
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL pri_in_rel: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    tick();
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL pri_out_req: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    if (io.bus_out !== 8'h5A) begin $display("[TB] FAIL pri_out_bus: got %h want 5a", io.bus_out); n_bad++; end n_cmp++;
    io.hsk_in = 1'b1;
    tick(3);
    if (io.wr_busy !== 1'b0) begin $display("[TB] FAIL pri_out_ack: got %b want 0", io.wr_busy); n_bad++; end n_cmp++;
    io.hsk_in = 1'b0;
    tick(3);
    pop_once();
    if (io.rd_valid !== 1'b0) begin $display("[TB] FAIL pri_drained: got %b want 0", io.rd_valid); n_bad++; end n_cmp++;
  endtask

  task automatic test_push_pop();
    bit ok;
    device_send(8'h11, ok);
    if (!ok) begin $display("[TB] FAIL pp_send11: got timeout want handshake", ); n_bad++; end n_cmp++;
    device_send(8'h22, ok);
    if (!ok) begin $display("[TB] FAIL pp_send22: got timeout want handshake"); n_bad++; end n_cmp++;
    io.bus_in = 8'h33;
    io.hsk_in = 1'b1;
    tick(2);
    io.rd_req = 1'b1;
    tick();
    io.rd_req = 1'b0;
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL pp_push: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    if (io.rd_data !== 8'h22) begin $display("[TB] FAIL pp_head: got %h want 22", io.rd_data); n_bad++; end n_cmp++;
    io.hsk_in = 1'b0;
    tick(3);
    pop_once();
    if (io.rd_data !== 8'h33) begin $display("[TB] FAIL pp_second: got %h want 33", io.rd_data); n_bad++; end n_cmp++;
    if (io.rd_valid !== 1'b1) begin $display("[TB] FAIL pp_count2: got %b want 1", io.rd_valid); n_bad++; end n_cmp++;
    pop_once();
    if (io.rd_valid !== 1'b0) begin $display("[TB] FAIL pp_empty: got %b want 0", io.rd_valid); n_bad++; end n_cmp++;
  endtask

  task automatic test_reset_mid();
    io.wr_data = 8'h99;
    io.wr_req  = 1'b1;
    tick();
    io.wr_req = 1'b0;
    tick();
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL rm_out_req: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    #1 g_clr = 1'b1;
    #1;
    if (io.hsk_out !== 1'b0) begin $display("[TB] FAIL rm_hsk_out: got %b want 0", io.hsk_out); n_bad++; end n_cmp++;
    if (io.bus_out !== 8'h00) begin $display("[TB] FAIL rm_bus_out: got %h want 00", io.bus_out); n_bad++; end n_cmp++;
    if (io.wr_busy !== 1'b0) begin $display("[TB] FAIL rm_wr_busy: got %b want 0", io.wr_busy); n_bad++; end n_cmp++;
    tick();
    g_clr = 1'b0;
    tick();
    io.bus_in = 8'h42;
    io.hsk_in = 1'b1;
    tick(3);
    if (io.hsk_out !== 1'b1) begin $display("[TB] FAIL rm_idle_ack: got %b want 1", io.hsk_out); n_bad++; end n_cmp++;
    if (io.rd_data !== 8'h42) begin $display("[TB] FAIL rm_idle_data: got %h want 42", io.rd_data); n_bad++; end n_cmp++;
    io.hsk_in = 1'b0;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_single_input();
    test_backpressure();
    test_output();
    test_priority();
    test_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
